// File: rtl/interrupt_controller.sv
// Edge-latched, maskable, fixed-priority interrupt source for the PC interrupt port.
// Dispatches one vector at a time and blocks further dispatch until reti.
module irq_lane (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic clr,
    output logic pending
);
    logic irq_q;
    logic rise;

    assign rise = irq_in & ~irq_q;

    // A new edge coinciding with the clear keeps the bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            irq_q   <= irq_in;
            pending <= rise | (pending & ~clr);
        end
    end
endmodule

module interrupt_controller #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] ISR_BASE   = 32'h0000_0040,
    parameter logic [31:0] ISR_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic [31:0]        ret_addr,
    input  logic               reti,
    output logic               interrupt,
    output logic [31:0]        pc_isr,
    output logic [31:0]        epc,
    output logic               in_service,
    output logic [3:0]         active_id,
    output logic [NUM_IRQ-1:0] pending
);
    typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [3:0]         win_id;

    genvar g;
    generate
        for (g = 0; g < NUM_IRQ; g++) begin : g_lane
            assign clr[g] = (state == FIRE) && (active_id == 4'(g));
            irq_lane u_lane (
                .clk     (clk),
                .rst     (rst),
                .irq_in  (irq_in[g]),
                .clr     (clr[g]),
                .pending (pending[g])
            );
        end
    endgenerate

    assign eligible = pending & mask;

    // Scan high to low so the lowest set index is the last assignment
    always_comb begin
        win_id = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (eligible[i]) win_id = 4'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask <= '0;
        else if (mask_wr)
            mask <= mask_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            pc_isr     <= 32'd0;
            epc        <= 32'd0;
            in_service <= 1'b0;
            active_id  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        active_id <= win_id;
                        pc_isr    <= ISR_BASE + 32'(win_id) * ISR_STRIDE;
                        epc       <= ret_addr;
                        interrupt <= 1'b1;
                        state     <= FIRE;
                    end
                end
                FIRE: begin
                    interrupt  <= 1'b0;
                    in_service <= 1'b1;
                    state      <= SERVICE;
                end
                SERVICE: begin
                    if (reti) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: expected dispatches are queued at stimulus time and checked on each interrupt pulse.
module tb_interrupt_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_in = '0;
    logic        mask_wr = 1'b0;
    logic [3:0]  mask_wdata = '0;
    logic [31:0] ret_addr = '0;
    logic        reti = 1'b0;
    logic        interrupt;
    logic [31:0] pc_isr;
    logic [31:0] epc;
    logic        in_service;
    logic [3:0]  active_id;
    logic [3:0]  pending;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] pc;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pulses = 0;
    logic prev_int = 1'b0;

    interrupt_controller #(
        .NUM_IRQ(4), .ISR_BASE(32'h40), .ISR_STRIDE(32'h10)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
        .mask_wdata(mask_wdata), .ret_addr(ret_addr), .reti(reti),
        .interrupt(interrupt), .pc_isr(pc_isr), .epc(epc),
        .in_service(in_service), .active_id(active_id), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] pc, input logic [31:0] e);
        exp_t x;
        x.id = id; x.pc = pc; x.epc = e;
        sb.push_back(x);
    endtask

    // Monitor: every pulse must match the next queued dispatch
    always @(negedge clk) begin
        if (interrupt) begin
            exp_t x;
            pulses++;
            chk("int_not_back_to_back", {31'd0, prev_int}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_interrupt", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("sb_active_id", {28'd0, active_id}, {28'd0, x.id});
                chk("sb_pc_isr", pc_isr, x.pc);
                chk("sb_epc", epc, x.epc);
            end
        end
        prev_int = interrupt;
    end

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
        chk("rst_pc_isr", pc_isr, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_in_service", {31'd0, in_service}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        rst = 1'b0;

        // Single IRQ2 dispatch
        mask_wr = 1'b1; mask_wdata = 4'hF;
        tick();
        mask_wr = 1'b0;
        irq_in = 4'b0100; ret_addr = 32'h100; push(4'd2, 32'h60, 32'h100);
        tick();
        chk("t1_pending_set", {28'd0, pending}, 32'h4);
        chk("t1_no_int_yet", {31'd0, interrupt}, 32'd0);
        tick();
        chk("t1_interrupt", {31'd0, interrupt}, 32'd1);
        chk("t1_pc_isr", pc_isr, 32'h60);
        chk("t1_epc", epc, 32'h100);
        tick();
        chk("t1_int_drop", {31'd0, interrupt}, 32'd0);
        chk("t1_in_service", {31'd0, in_service}, 32'd1);
        chk("t1_active_id", {28'd0, active_id}, 32'd2);
        chk("t1_pending_clr", {28'd0, pending}, 32'd0);
        tick(); tick();
        chk("t1_pulses", pulses, 32'd1);
        irq_in = 4'b0000;
        do_reti();
        chk("t1_reti", {31'd0, in_service}, 32'd0);
        tick(); tick();
        chk("t1_pulses_after", pulses, 32'd1);

        // Simultaneous IRQ1 and IRQ3: priority, then IRQ3 after return
        irq_in = 4'b1010; ret_addr = 32'h200; push(4'd1, 32'h50, 32'h200);
        tick();
        chk("t2_pending", {28'd0, pending}, 32'hA);
        tick();
        chk("t2_interrupt", {31'd0, interrupt}, 32'd1);
        chk("t2_pc_isr", pc_isr, 32'h50);
        tick();
        chk("t2_pending3", {28'd0, pending}, 32'h8);
        chk("t2_in_service", {31'd0, in_service}, 32'd1);
        tick(); tick();
        chk("t2_pulses", pulses, 32'd2);
        ret_addr = 32'h300; push(4'd3, 32'h70, 32'h300);
        do_reti();
        chk("t2_reti", {31'd0, in_service}, 32'd0);
        tick();
        chk("t2_int3", {31'd0, interrupt}, 32'd1);
        chk("t2_pc_isr3", pc_isr, 32'h70);
        chk("t2_epc3", epc, 32'h300);
        tick();
        chk("t2_pending_empty", {28'd0, pending}, 32'd0);
        irq_in = 4'b0000;
        do_reti();
        tick(); tick();
        chk("t2_pulses_after", pulses, 32'd3);

        // Masked IRQ0 stays pending, dispatches after mask write
        mask_wr = 1'b1; mask_wdata = 4'b0000; irq_in = 4'b0001;
        tick();
        mask_wr = 1'b0;
        tick(); tick(); tick();
        chk("t3_pending_masked", {28'd0, pending}, 32'h1);
        chk("t3_no_pulse", pulses, 32'd3);
        ret_addr = 32'h400; push(4'd0, 32'h40, 32'h400);
        mask_wr = 1'b1; mask_wdata = 4'b0001;
        tick();
        mask_wr = 1'b0;
        chk("t3_no_int_yet", {31'd0, interrupt}, 32'd0);
        tick();
        chk("t3_interrupt", {31'd0, interrupt}, 32'd1);
        chk("t3_pc_isr", pc_isr, 32'h40);
        tick();
        chk("t3_in_service", {31'd0, in_service}, 32'd1);

        // Re-edge on IRQ0 during service: held off until return
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0001;
        tick();
        chk("t4_pending_again", {28'd0, pending}, 32'h1);
        tick(); tick(); tick();
        chk("t4_no_nesting", pulses, 32'd4);
        chk("t4_still_service", {31'd0, in_service}, 32'd1);
        ret_addr = 32'h500; push(4'd0, 32'h40, 32'h500);
        do_reti();
        tick();
        chk("t4_redispatch", {31'd0, interrupt}, 32'd1);
        chk("t4_epc", epc, 32'h500);
        tick();
        irq_in = 4'b0000;
        do_reti();
        tick(); tick(); tick();
        chk("t4_pulses", pulses, 32'd5);
        chk("t4_idle", {31'd0, in_service}, 32'd0);

        // Edge on IRQ2 coinciding with its FIRE cycle: set wins
        mask_wr = 1'b1; mask_wdata = 4'hF;
        irq_in = 4'b0100; ret_addr = 32'h600; push(4'd2, 32'h60, 32'h600);
        tick();
        mask_wr = 1'b0; irq_in = 4'b0000;
        tick();
        chk("t5_interrupt", {31'd0, interrupt}, 32'd1);
        irq_in = 4'b0100;
        tick();
        chk("t5_set_wins", {28'd0, pending}, 32'h4);
        chk("t5_in_service", {31'd0, in_service}, 32'd1);
        ret_addr = 32'h700; push(4'd2, 32'h60, 32'h700);
        do_reti();
        tick();
        chk("t5_redispatch", {31'd0, interrupt}, 32'd1);
        chk("t5_epc", epc, 32'h700);
        tick();
        chk("t5_pending_clr", {28'd0, pending}, 32'd0);
        irq_in = 4'b0000;
        do_reti();
        tick(); tick();
        chk("t5_pulses", pulses, 32'd7);

        // Asynchronous reset in the middle of service
        irq_in = 4'b0010; ret_addr = 32'h800; push(4'd1, 32'h50, 32'h800);
        tick(); tick(); tick();
        chk("t6_in_service", {31'd0, in_service}, 32'd1);
        irq_in = 4'b1010;
        tick();
        chk("t6_pending3", {28'd0, pending}, 32'h8);
        #3;
        rst = 1'b1; irq_in = 4'b0000;
        #1;
        chk("t6_rst_in_service", {31'd0, in_service}, 32'd0);
        chk("t6_rst_pending", {28'd0, pending}, 32'd0);
        chk("t6_rst_pc_isr", pc_isr, 32'd0);
        chk("t6_rst_epc", epc, 32'd0);
        chk("t6_rst_active_id", {28'd0, active_id}, 32'd0);
        chk("t6_rst_interrupt", {31'd0, interrupt}, 32'd0);
        tick();
        rst = 1'b0;
        mask_wr = 1'b1; mask_wdata = 4'hF;
        tick();
        mask_wr = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t6_no_pulse", pulses, 32'd8);
        chk("t6_pending_idle", {28'd0, pending}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
